card_display_scan: RTL

CARD_DISPLAY_SCAN -- requirements
Module: card_display_scan

---
 rtl/card_display_scan.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/card_display_scan.sv
// Eight-slot card-rank display scanner with a sequential clear sweep.
// Optional highlight blinking is enabled by defining CARD_DISPLAY_BLINK_EN.
module card_display_scan #(
    parameter int COUNT_PERIOD = 100000,
    parameter int BLINK_PERIOD = 25000000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       load_valid_in,
    input  logic [2:0] load_idx_in,
    input  logic [3:0] load_rank_in,
    output logic       load_ready_out,
    input  logic       clear_in,
    input  logic [7:0] highlight_in,
    output logic [3:0] rank_out,
    input  logic [6:0] seg_in,
    output logic [6:0] cat_out,
    output logic [7:0] an_out
);

    localparam int CW = $clog2(COUNT_PERIOD);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state_q, state_d;
    logic [2:0]  clr_idx_q, clr_idx_d;
    logic [3:0]  slot_q [0:7];
    logic [3:0]  slot_d [0:7];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  digit_q, digit_d;
    logic [6:0]  cat_q, cat_d;
    logic [7:0]  an_q, an_d;

`ifdef CARD_DISPLAY_BLINK_EN
    localparam int BW = $clog2(BLINK_PERIOD);
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
`else
    localparam int UNUSED_BLINK_PERIOD = BLINK_PERIOD;
    logic highlight_unused;
    assign highlight_unused = ^highlight_in;
`endif

    assign rank_out = slot_q[digit_q];
    assign cat_out  = cat_q;
    assign an_out   = an_q;

    // Clear wins over a simultaneous load; nothing is accepted while sweeping.
    assign load_ready_out = (state_q == IDLE) && !clear_in && !rst_in;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        for (int i = 0; i < 8; i++) begin
            slot_d[i] = slot_q[i];
        end

        if (load_valid_in && load_ready_out) begin
            slot_d[load_idx_in] = load_rank_in;
        end

        case (state_q)
            IDLE: begin
                if (clear_in) begin
                    state_d   = CLEAR;
                    clr_idx_d = 3'd0;
                end
            end
            CLEAR: begin
                slot_d[clr_idx_q] = 4'd0;
                clr_idx_d         = clr_idx_q + 3'd1;
                if (clr_idx_q == 3'd7) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        digit_d = digit_q;
        if (cnt_q == CW'(COUNT_PERIOD - 1)) begin
            cnt_d   = '0;
            digit_d = digit_q + 3'd1;
        end

        cat_d = ~seg_in;
        // Counter at zero marks the first cycle of a digit: blank it to avoid ghosting.
        if (cnt_q == '0) begin
            an_d = 8'hFF;
        end else begin
            an_d = ~(8'b1 << digit_q);
        end

`ifdef CARD_DISPLAY_BLINK_EN
        blink_cnt_d = blink_cnt_q + BW'(1);
        phase_d     = phase_q;
        if (blink_cnt_q == BW'(BLINK_PERIOD - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
        if (phase_q && highlight_in[digit_q]) begin
            an_d = 8'hFF;
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            clr_idx_q <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                slot_q[i] <= 4'd0;
            end
            cnt_q     <= '0;
            digit_q   <= 3'd0;
            cat_q     <= 7'h7F;
            an_q      <= 8'hFF;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            for (int i = 0; i < 8; i++) begin
                slot_q[i] <= slot_d[i];
            end
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            cat_q     <= cat_d;
            an_q      <= an_d;
        end
    end

`ifdef CARD_DISPLAY_BLINK_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end
`endif

endmodule
